data_memory_unit: RTL and testbench

- LEGv8 data memory stage sitting directly upstream of the write-back mux.
- Services LDUR/STUR-family accesses of byte, half, word and doubleword size, with optional sign extension on loads.
- Uses a fixed-latency wait-state handshake.
- Its registered load result `data_mem_out` drives the write-back mux's `data_mem_in` input; the mux selects it when the mux control is 1.

---
 rtl/legv8_pkg.sv | 14 +
 rtl/mem_lane_align.sv | 32 +++
 rtl/data_memory_unit.sv | 111 +++++++++++
 tb/tb_data_memory_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// legv8_pkg: access-size and state encodings shared by the LEGv8 data memory stage
package legv8_pkg;
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane extract/extend for loads, byte merge for stores, alignment check
module mem_lane_align
    import legv8_pkg::*;
(
    input  size_e       size_i,
    input  logic        sign_ext_i,
    input  logic [2:0]  lane_i,
    input  logic [63:0] word_i,
    input  logic [63:0] wdata_i,
    input  size_e       chk_size_i,
    input  logic [2:0]  chk_lane_i,
    output logic [63:0] load_o,
    output logic [63:0] merged_o,
    output logic        aligned_o
);
    logic [5:0]  shamt;
    logic [63:0] field;
    logic [63:0] fmask;
    logic        msb;
    // Shift the addressed lane down for loads, up under a byte mask for stores
    always_comb begin
        shamt     = {lane_i, 3'b000};
        field     = word_i >> shamt;
        fmask     = size_i == SZ_B ? 64'hFF : size_i == SZ_H ? 64'hFFFF :
                    size_i == SZ_W ? 64'hFFFF_FFFF : '1;
        msb       = size_i == SZ_B ? field[7] : size_i == SZ_H ? field[15] : field[31];
        load_o    = size_i != SZ_D && sign_ext_i && msb ? (field | ~fmask) : (field & fmask);
        merged_o  = (word_i & ~(fmask << shamt)) | ((wdata_i & fmask) << shamt);
        aligned_o = chk_size_i == SZ_B ? 1'b1 : chk_size_i == SZ_H ? !chk_lane_i[0] :
                    chk_size_i == SZ_W ? chk_lane_i[1:0] == 2'b00 : chk_lane_i == 3'b000;
    end
endmodule

// File: rtl/data_memory_unit.sv
// data_memory_unit: LEGv8 data memory with fixed wait states, sized/extended loads, RMW stores
module data_memory_unit
    import legv8_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [63:0] address,
    input  logic [63:0] write_data,
    output logic [63:0] data_mem_out,
    output logic        mem_busy,
    output logic        mem_done,
    output logic        mem_fault
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic [2:0]    lane_q;
    size_e         size_q;
    logic          sext_q, write_q;
    logic [63:0]   wdata_q, dout_q;
    logic          done_q, fault_q;
    logic [63:0]   mem_q [DEPTH_WORDS];
    logic [63:0]   word, load_val, merged;
    logic          open, in_range, aligned, accept, reject;

    assign word = mem_q[idx_q];

    mem_lane_align u_align (
        .size_i     (size_q),
        .sign_ext_i (sext_q),
        .lane_i     (lane_q),
        .word_i     (word),
        .wdata_i    (wdata_q),
        .chk_size_i (size_e'(size)),
        .chk_lane_i (address[2:0]),
        .load_o     (load_val),
        .merged_o   (merged),
        .aligned_o  (aligned)
    );

    // Request qualification; RESP also accepts so a held request streams without a gap
    always_comb begin
        open     = state_q != WAIT;
        in_range = address[63:3] < 61'(DEPTH_WORDS);
        accept   = open && (mem_read ^ mem_write) && aligned && in_range;
        reject   = open && (mem_read || mem_write) && !accept;
    end

    // Next state and wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == WAIT) begin
            cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
            state_d = cnt_q == 4'd0 ? RESP : WAIT;
        end else begin
            state_d = accept ? (WAIT_STATES == 0 ? RESP : WAIT) : IDLE;
            cnt_d   = accept && WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
        end
    end

    // Control state, latched request and registered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            size_q  <= SZ_B;
            sext_q  <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= state_q == RESP;
            fault_q <= reject;
            if (state_q == RESP && !write_q) dout_q <= load_val;
            if (accept) begin
                idx_q   <= address[AW+2:3];
                lane_q  <= address[2:0];
                size_q  <= size_e'(size);
                sext_q  <= sign_ext;
                write_q <= mem_write;
                wdata_q <= write_data;
            end
        end
    end

    // Storage array is never cleared; a reset before RESP leaves it untouched
    always_ff @(posedge clk) begin
        if (state_q == RESP && write_q) mem_q[idx_q] <= merged;
    end

    assign data_mem_out = dout_q;
    assign mem_busy     = state_q == WAIT;
    assign mem_done     = done_q;
    assign mem_fault    = fault_q;
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: randomized and directed checks against a byte-array reference model
module tb_data_memory_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        rd = 1'b0, wr = 1'b0, sx = 1'b0;
    logic [1:0]  sz = 2'b00;
    logic [63:0] a = '0, wd = '0;
    logic [63:0] dout;
    logic        busy, done, fault;

    logic        rd0 = 1'b0, wr0 = 1'b0;
    logic [63:0] a0 = '0, wd0 = '0;
    logic [63:0] dout0;
    logic        busy0, done0, fault0;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  ref_mem [2048];
    logic [63:0] ref_dout = '0;

    data_memory_unit #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(rd), .mem_write(wr), .size(sz), .sign_ext(sx),
        .address(a), .write_data(wd), .data_mem_out(dout), .mem_busy(busy),
        .mem_done(done), .mem_fault(fault)
    );

    data_memory_unit #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mem_read(rd0), .mem_write(wr0), .size(2'b11), .sign_ext(1'b0),
        .address(a0), .write_data(wd0), .data_mem_out(dout0), .mem_busy(busy0),
        .mem_done(done0), .mem_fault(fault0)
    );

    // Reference: memory as 2048 little-endian bytes; returns 1 when the request must be rejected
    function automatic bit model_apply(logic r, logic w, logic [1:0] s, logic x,
                                       logic [63:0] ad, logic [63:0] d);
        int nb = 1 << s;
        int base;
        logic [63:0] v;
        if ((r && w) || (ad % nb) != 0 || (ad >> 3) >= 256) return 1'b1;
        base = int'(ad[10:0]);
        if (w) begin
            for (int i = 0; i < nb; i++) ref_mem[base + i] = d[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[base + i];
            if (x && nb < 8 && v[8*nb - 1]) v = v | (~64'd0 << (8*nb));
            ref_dout = v;
        end
        return 1'b0;
    endfunction

    // Present one request for one edge, then observe a fixed window of six cycles
    task automatic access(input logic r, input logic w, input logic [1:0] s, input logic x,
                          input logic [63:0] ad, input logic [63:0] d,
                          output int done_n, output int done_lat, output int fault_n,
                          output int fault_lat, output int busy_n);
        rd = r; wr = w; sz = s; sx = x; a = ad; wd = d;
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        done_n = 0; fault_n = 0; busy_n = 0; done_lat = -1; fault_lat = -1;
        for (int n = 0; n < 6; n++) begin
            if (done) begin done_n++; if (done_lat < 0) done_lat = n; end
            if (fault) begin fault_n++; if (fault_lat < 0) fault_lat = n; end
            busy_n += int'(busy);
            if (n < 5) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({dout, busy, done, fault} !== 67'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got dout=%h busy=%b done=%b fault=%b, want all 0", dout, busy, done, fault);
        end
        vectors++;
        if ({dout0, busy0, done0, fault0} !== 67'd0) begin
            miscompares++;
            $display("FAIL reset_outputs_ws0: got dout=%h busy=%b done=%b fault=%b, want all 0", dout0, busy0, done0, fault0);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic init_memory();
        int dn, dl, fn, fl, bn;
        logic [63:0] d;
        for (int i = 0; i < 256; i++) begin
            d = {$urandom, $urandom};
            void'(model_apply(1'b0, 1'b1, 2'b11, 1'b0, 64'(i) << 3, d));
            access(1'b0, 1'b1, 2'b11, 1'b0, 64'(i) << 3, d, dn, dl, fn, fl, bn);
            vectors++;
            if (dn !== 1 || fn !== 0) begin
                miscompares++;
                $display("FAIL init_store[%0d]: got done=%0d fault=%0d, want 1/0", i, dn, fn);
            end
        end
    endtask

    task automatic test_store_load();
        int dn, dl, fn, fl, bn;
        void'(model_apply(1'b0, 1'b1, 2'b11, 1'b0, 64'h10, 64'h1122334455667788));
        access(1'b0, 1'b1, 2'b11, 1'b0, 64'h10, 64'h1122334455667788, dn, dl, fn, fl, bn);
        vectors++;
        if (bn !== 2) begin miscompares++; $display("FAIL store_busy_cycles: got %0d want 2", bn); end
        vectors++;
        if (dn !== 1 || dl !== 3) begin miscompares++; $display("FAIL store_done: got count=%0d lat=%0d want 1/3", dn, dl); end
        vectors++;
        if (dout !== 64'd0) begin miscompares++; $display("FAIL store_leaves_dout: got %h want 0", dout); end
        void'(model_apply(1'b1, 1'b0, 2'b11, 1'b0, 64'h10, 64'd0));
        access(1'b1, 1'b0, 2'b11, 1'b0, 64'h10, 64'd0, dn, dl, fn, fl, bn);
        vectors++;
        if (dn !== 1 || dl !== 3) begin miscompares++; $display("FAIL load_done: got count=%0d lat=%0d want 1/3", dn, dl); end
        vectors++;
        if (dout !== 64'h1122334455667788) begin
            miscompares++;
            $display("FAIL load_double: got %h want 1122334455667788", dout);
        end
    endtask

    task automatic test_lanes();
        int dn, dl, fn, fl, bn;
        logic        t_r [4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [1:0]  t_s [4]  = '{2'b00, 2'b00, 2'b00, 2'b01};
        logic        t_x [4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [63:0] t_a [4]  = '{64'h17, 64'h10, 64'h10, 64'h12};
        logic [63:0] t_d [4]  = '{64'h0, 64'hAAAA_BBBB_CCCC_DDF0, 64'h0, 64'h0};
        logic [63:0] t_e [4]  = '{64'h11, 64'h11, 64'hFFFF_FFFF_FFFF_FFF0, 64'h5566};
        for (int i = 0; i < 4; i++) begin
            void'(model_apply(t_r[i], !t_r[i], t_s[i], t_x[i], t_a[i], t_d[i]));
            access(t_r[i], !t_r[i], t_s[i], t_x[i], t_a[i], t_d[i], dn, dl, fn, fl, bn);
            vectors++;
            if (dout !== t_e[i] || dn !== 1 || fn !== 0) begin
                miscompares++;
                $display("FAIL lane[%0d]: got dout=%h done=%0d fault=%0d want %h/1/0", i, dout, dn, fn, t_e[i]);
            end
        end
    endtask

    task automatic test_faults();
        int dn, dl, fn, fl, bn;
        logic        t_r [3] = '{1'b1, 1'b1, 1'b1};
        logic        t_w [3] = '{1'b0, 1'b0, 1'b1};
        logic [1:0]  t_s [3] = '{2'b11, 2'b11, 2'b11};
        logic [63:0] t_a [3] = '{64'h0C, 64'h800, 64'h10};
        logic [63:0] prev;
        for (int i = 0; i < 3; i++) begin
            prev = ref_dout;
            access(t_r[i], t_w[i], t_s[i], 1'b0, t_a[i], 64'hFFFF, dn, dl, fn, fl, bn);
            vectors++;
            if (fn !== 1 || fl !== 0 || dn !== 0 || bn !== 0) begin
                miscompares++;
                $display("FAIL fault[%0d]: got fault=%0d lat=%0d done=%0d busy=%0d want 1/0/0/0", i, fn, fl, dn, bn);
            end
            vectors++;
            if (dout !== prev) begin miscompares++; $display("FAIL fault_dout[%0d]: got %h want %h", i, dout, prev); end
        end
        void'(model_apply(1'b1, 1'b0, 2'b11, 1'b0, 64'h10, 64'd0));
        access(1'b1, 1'b0, 2'b11, 1'b0, 64'h10, 64'd0, dn, dl, fn, fl, bn);
        vectors++;
        if (dout !== ref_dout) begin miscompares++; $display("FAIL fault_no_write: got %h want %h", dout, ref_dout); end
    endtask

    task automatic test_busy_ignore();
        int dn, dl, fn, fl, bn;
        logic [63:0] expv;
        void'(model_apply(1'b1, 1'b0, 2'b11, 1'b0, 64'h28, 64'd0));
        expv = ref_dout;
        rd = 1'b1; sz = 2'b11; sx = 1'b0; a = 64'h28; wd = ~expv;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            wr = 1'b0;
            vectors++;
            if (done !== (n > 0 && n % 3 == 0) || fault !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_stream[%0d]: got done=%b fault=%b want done=%b fault=0", n, done, fault, n > 0 && n % 3 == 0);
            end
            if (busy && n < 9) wr = 1'b1;
        end
        rd = 1'b0; wr = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (dout !== expv) begin miscompares++; $display("FAIL busy_stream_dout: got %h want %h", dout, expv); end
        access(1'b1, 1'b0, 2'b11, 1'b0, 64'h28, 64'd0, dn, dl, fn, fl, bn);
        vectors++;
        if (dout !== expv || dn !== 1) begin
            miscompares++;
            $display("FAIL busy_write_ignored: got %h done=%0d want %h/1", dout, dn, expv);
        end
    endtask

    task automatic test_reset_mid_store();
        int dn, dl, fn, fl, bn;
        rd = 1'b0; wr = 1'b1; sz = 2'b11; sx = 1'b0; a = 64'h20; wd = 64'hDEAD;
        @(negedge clk);
        wr = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL midstore_accept: got busy=%b want 1", busy); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({dout, busy, done, fault} !== 67'd0) begin
            miscompares++;
            $display("FAIL midstore_reset: got dout=%h busy=%b done=%b fault=%b want all 0", dout, busy, done, fault);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL midstore_no_done: got %b want 0", done); end
        void'(model_apply(1'b1, 1'b0, 2'b11, 1'b0, 64'h20, 64'd0));
        access(1'b1, 1'b0, 2'b11, 1'b0, 64'h20, 64'd0, dn, dl, fn, fl, bn);
        vectors++;
        if (dout !== ref_dout) begin miscompares++; $display("FAIL midstore_not_committed: got %h want %h", dout, ref_dout); end
    endtask

    task automatic test_random();
        int dn, dl, fn, fl, bn, k, nb;
        logic r, w, x;
        logic [1:0] s;
        logic [63:0] ad, d;
        bit exp_fault;
        for (int i = 0; i < 80; i++) begin
            s  = 2'($urandom_range(0, 3));
            nb = 1 << s;
            ad = (64'($urandom_range(0, 263)) << 3) | 64'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) ad = ad & ~64'(nb - 1);
            if ($urandom_range(0, 19) == 0) ad[45] = 1'b1;
            k  = $urandom_range(0, 9);
            r  = k == 0 || k < 6;
            w  = k == 0 || k >= 6;
            x  = 1'($urandom_range(0, 1));
            d  = {$urandom, $urandom};
            exp_fault = model_apply(r, w, s, x, ad, d);
            access(r, w, s, x, ad, d, dn, dl, fn, fl, bn);
            vectors++;
            if (fn !== int'(exp_fault) || dn !== int'(!exp_fault) || (!exp_fault && dl !== 3)) begin
                miscompares++;
                $display("FAIL rand[%0d] handshake: got done=%0d lat=%0d fault=%0d want fault=%0d", i, dn, dl, fn, exp_fault);
            end
            vectors++;
            if (dout !== ref_dout) begin
                miscompares++;
                $display("FAIL rand[%0d] dout: r=%b w=%b sz=%0d sx=%b addr=%h got %h want %h", i, r, w, s, x, ad, dout, ref_dout);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] va, vb;
        logic        e_done [4];
        logic [63:0] e_dout [4];
        va = {$urandom, $urandom};
        vb = {$urandom, $urandom};
        e_done = '{1'b0, 1'b1, 1'b1, 1'b0};
        e_dout = '{64'd0, 64'd0, 64'd0, 64'd0};
        for (int p = 0; p < 2; p++) begin
            if (p == 1) e_dout = '{dout0, va, vb, vb};
            rd0 = p == 1; wr0 = p == 0; a0 = 64'h0; wd0 = va;
            for (int n = 0; n < 4; n++) begin
                @(negedge clk);
                if (n == 0) begin a0 = 64'h8; wd0 = vb; end
                if (n == 1) begin rd0 = 1'b0; wr0 = 1'b0; end
                vectors++;
                if (done0 !== e_done[n] || busy0 !== 1'b0 || fault0 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ws0_pass%0d[%0d]: got done=%b busy=%b fault=%b want %b/0/0", p, n, done0, busy0, fault0, e_done[n]);
                end
                vectors++;
                if (dout0 !== e_dout[n]) begin
                    miscompares++;
                    $display("FAIL ws0_dout_pass%0d[%0d]: got %h want %h", p, n, dout0, e_dout[n]);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        init_memory();
        test_store_load();
        test_lanes();
        test_faults();
        test_busy_ignore();
        test_reset_mid_store();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
